fp_mult_pipe: RTL

//  Parametrised, pipelined IEEE-754-style floating-point multiplier: result = op_a * op_b.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_round_rne.sv | 24 ++
 rtl/fp_mult_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// the canonical quiet NaN pattern for an arbitrary exponent/fraction split.
package fp_pkg;

    typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fp_cls_e;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    // Returned wide; callers size-cast down to their own word width.
    function automatic logic [127:0] canon_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << man_w;
        v = v | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand with guard/round/sticky.
// A carry-out comes back already renormalised (1.000...), the caller bumps the exponent.
module fp_round_rne #(
    parameter int MAN_W = 23
) (
    input  logic [MAN_W:0] mant_in,
    input  logic           g,
    input  logic           r,
    input  logic           s,
    output logic [MAN_W:0] mant_out,
    output logic           carry,
    output logic           inexact
);

    logic           inc;
    logic [MAN_W+1:0] sum;

    assign inc      = g & (r | s | mant_in[0]);
    assign sum      = {1'b0, mant_in} + {{(MAN_W+1){1'b0}}, inc};
    assign carry    = sum[MAN_W+1];
    assign mant_out = carry ? sum[MAN_W+1:1] : sum[MAN_W:0];
    assign inexact  = g | r | s;

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier (unpack / normalise / round+pack) with a
// single global stall: every stage holds while the output is valid and not taken.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int STAGES = 3;
    localparam int BIAS   = 2**(EXP_W-1) - 1;
    localparam int P      = 2 * (MAN_W + 1);
    localparam int EW     = EXP_W + 2;

    typedef logic signed [EW-1:0] exp_t;

    localparam exp_t         BIAS_X = exp_t'(BIAS);
    localparam exp_t         EMAX   = exp_t'(2**EXP_W - 1);
    localparam logic [W-1:0] QNAN_W = W'(canon_qnan(EXP_W, MAN_W));

    typedef struct packed {
        logic          sign;
        fp_cls_e       ca;
        fp_cls_e       cb;
        exp_t          e;
        logic [P-1:0]  prod;
    } s1_t;

    typedef struct packed {
        logic           sign;
        fp_cls_e        ca;
        fp_cls_e        cb;
        exp_t           e;
        logic [MAN_W:0] mant;
        logic           g;
        logic           r;
        logic           s;
    } s2_t;

    // Subnormal inputs fold into ZERO (denormals-are-zero).
    function automatic fp_cls_e classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] ex;
        logic [MAN_W-1:0] fr;
        ex = x[W-2:MAN_W];
        fr = x[MAN_W-1:0];
        if (ex == '0)
            return ZERO;
        else if (&ex)
            return (fr == '0) ? INF : (fr[MAN_W-1] ? QNAN : SNAN);
        else
            return NORM;
    endfunction

    logic [STAGES:1] vld_pipe;
    logic            advance;
    s1_t             s1_d, s1_q;
    s2_t             s2_d, s2_q;
    logic [P-1:0]    norm;
    logic [MAN_W:0]  mant_r;
    logic            carry, inexact;
    exp_t            e_f;
    logic [W-1:0]    res_d;
    logic [3:0]      flg_d;
    logic            nan_in, snan_in, inf_in, zero_in, inf_zero;
    logic            mant_hi_unused;

    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    always_comb begin
        s1_d.sign = op_a[W-1] ^ op_b[W-1];
        s1_d.ca   = classify(op_a);
        s1_d.cb   = classify(op_b);
        s1_d.e    = exp_t'({2'b00, op_a[W-2:MAN_W]}) + exp_t'({2'b00, op_b[W-2:MAN_W]}) - BIAS_X;
        s1_d.prod = P'({1'b1, op_a[MAN_W-1:0]}) * P'({1'b1, op_b[MAN_W-1:0]});
    end

    // Product lies in [1,4); a set MSB means it needs one right shift.
    always_comb begin
        norm      = s1_q.prod[P-1] ? s1_q.prod : (s1_q.prod << 1);
        s2_d.sign = s1_q.sign;
        s2_d.ca   = s1_q.ca;
        s2_d.cb   = s1_q.cb;
        s2_d.e    = s1_q.e + exp_t'(s1_q.prod[P-1]);
        s2_d.mant = norm[P-1:MAN_W+1];
        s2_d.g    = norm[MAN_W];
        s2_d.r    = norm[MAN_W-1];
        s2_d.s    = |norm[MAN_W-2:0];
    end

    fp_round_rne #(.MAN_W(MAN_W)) u_rne (
        .mant_in  (s2_q.mant),
        .g        (s2_q.g),
        .r        (s2_q.r),
        .s        (s2_q.s),
        .mant_out (mant_r),
        .carry    (carry),
        .inexact  (inexact)
    );

    // Leading one is implicit in the packed format.
    assign mant_hi_unused = mant_r[MAN_W];
    assign e_f            = s2_q.e + exp_t'(carry);

    always_comb begin
        nan_in   = (s2_q.ca inside {QNAN, SNAN}) | (s2_q.cb inside {QNAN, SNAN});
        snan_in  = (s2_q.ca == SNAN) | (s2_q.cb == SNAN);
        inf_in   = (s2_q.ca == INF) | (s2_q.cb == INF);
        zero_in  = (s2_q.ca == ZERO) | (s2_q.cb == ZERO);
        inf_zero = inf_in & zero_in;
        res_d    = '0;
        flg_d    = '0;
        if (nan_in | inf_zero) begin
            res_d          = QNAN_W;
            flg_d[FLG_INV] = inf_zero | snan_in;
        end else if (inf_in) begin
            res_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_in) begin
            res_d = {s2_q.sign, {(W-1){1'b0}}};
        end else if (e_f >= EMAX) begin
            res_d          = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flg_d[FLG_OVF] = 1'b1;
            flg_d[FLG_NX]  = 1'b1;
        end else if (e_f[EW-1] || e_f == '0) begin
            res_d          = {s2_q.sign, {(W-1){1'b0}}};
            flg_d[FLG_UNF] = 1'b1;
            flg_d[FLG_NX]  = 1'b1;
        end else begin
            res_d         = {s2_q.sign, e_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
            flg_d[FLG_NX] = inexact;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            result   <= '0;
            flags    <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            result   <= res_d;
            flags    <= flg_d;
        end
    end

endmodule
